// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter sharing data_mem with registered request/response and access checks
module dmem_arbiter #(
   parameter int MEM_BYTES = 4096,
   parameter bit RR_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      req_valid,
   output logic [1:0]      req_ready,
   input  logic [1:0]      req_write,
   input  logic [1:0][1:0] req_size,
   input  logic [1:0][31:0] req_addr,
   input  logic [1:0][31:0] req_wdata,
   output logic [1:0]      rsp_valid,
   output logic [1:0][31:0] rsp_rdata,
   output logic [1:0]      rsp_err,
   output logic            mem_write,
   output logic [1:0]      mem_size,
   output logic [31:0]     mem_addr,
   output logic [31:0]     mem_wdata,
   input  logic [31:0]     mem_rdata
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t state_q, state_d;
   logic owner_q, owner_d, last_q, last_d, write_q, write_d, err_q, err_d;
   logic [1:0] size_q, size_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic win, hs, bad;
   logic [32:0] end_addr;
   always_comb begin
      win = &req_valid ? (RR_EN ? ~last_q : 1'b0) : req_valid[1];
      req_ready = (state_q != ACCESS && |req_valid) ? 2'b01 << win : 2'b00;
      hs = |req_ready;
      end_addr = {1'b0, req_addr[win]} + (req_size[win] == 2'd0 ? 33'd1 : req_size[win] == 2'd1 ? 33'd2 : 33'd4);
      bad = req_size[win] == 2'd3 || (req_size[win] == 2'd1 && req_addr[win][0]) ||
            (req_size[win] == 2'd2 && req_addr[win][1:0] != 2'd0) || end_addr > 33'(MEM_BYTES);
      state_d = state_q == ACCESS ? RESP : IDLE;
      owner_d = owner_q;
      last_d = last_q;
      err_d = err_q;
      write_d = write_q;
      size_d = size_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      rdata_d = state_q == ACCESS ? (write_q ? 32'd0 : mem_rdata) : rdata_q;
      if (hs) begin
         owner_d = win;
         last_d = win;
         err_d = bad;
         rdata_d = 32'd0;
         state_d = bad ? RESP : ACCESS;
         write_d = bad ? write_q : req_write[win];
         size_d = bad ? size_q : req_size[win];
         addr_d = bad ? addr_q : req_addr[win];
         wdata_d = bad ? wdata_q : req_wdata[win];
      end
      mem_write = state_q == ACCESS && write_q;
      mem_size = size_q;
      mem_addr = addr_q;
      mem_wdata = wdata_q;
      rsp_valid = state_q == RESP ? 2'b01 << owner_q : 2'b00;
      rsp_err = err_q ? rsp_valid : 2'b00;
      rsp_rdata[0] = rsp_valid[0] ? rdata_q : 32'd0;
      rsp_rdata[1] = rsp_valid[1] ? rdata_q : 32'd0;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q <= 1'b1;
         err_q <= 1'b0;
         write_q <= 1'b0;
         size_q <= 2'd0;
         addr_q <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q <= last_d;
         err_q <= err_d;
         write_q <= write_d;
         size_q <= size_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: transaction-level model plus directed vectors for dmem_arbiter
module tb_dmem_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [1:0] rv = 2'b00, rw = 2'b00;
   logic [1:0][1:0] rs = '0;
   logic [1:0][31:0] ra = '0, rwd = '0;
   logic [1:0] req_ready, rsp_valid, rsp_err;
   logic [1:0][31:0] rsp_rdata;
   logic mem_write;
   logic [1:0] mem_size;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [1:0] r2_ready, r2_valid, r2_err;
   logic [1:0][31:0] r2_rdata;
   logic m2_write;
   logic [1:0] m2_size;
   logic [31:0] m2_addr, m2_wdata;
   int checks = 0, failures = 0, mw_cnt = 0;
   bit chk_en = 1'b0;
   always #5 clk = ~clk;
   dmem_arbiter #(.MEM_BYTES(4096), .RR_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_ready(req_ready), .req_write(rw),
      .req_size(rs), .req_addr(ra), .req_wdata(rwd), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .mem_write(mem_write), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));
   dmem_arbiter #(.MEM_BYTES(4096), .RR_EN(1'b0)) dut_fp (
      .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_ready(r2_ready), .req_write(rw),
      .req_size(rs), .req_addr(ra), .req_wdata(rwd), .rsp_valid(r2_valid), .rsp_rdata(r2_rdata),
      .rsp_err(r2_err), .mem_write(m2_write), .mem_size(m2_size), .mem_addr(m2_addr),
      .mem_wdata(m2_wdata), .mem_rdata(32'd0));
   logic [7:0] dm [4096];
   logic [7:0] rm [4096];
   logic [11:0] ma;
   logic [31:0] mw;
   always_comb begin
      ma = mem_addr[11:0];
      mw = {dm[ma + 12'd3], dm[ma + 12'd2], dm[ma + 12'd1], dm[ma]};
      mem_rdata = mem_size == 2'd0 ? {24'd0, mw[7:0]} : mem_size == 2'd1 ? {16'd0, mw[15:0]} : mw;
   end
   always @(posedge clk)
      if (mem_write)
         for (int i = 0; i < 4; i++)
            if (i < (1 << mem_size)) dm[ma + 12'(i)] <= mem_wdata[8*i +: 8];
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
      end
   endtask
   function automatic logic [31:0] ld(input int a, input int s);
      logic [31:0] r = 0;
      for (int i = 0; i < (1 << s); i++) r[8*i +: 8] = rm[(a + i) % 4096];
      return r;
   endfunction
   typedef struct { bit v; bit p; bit e; logic [31:0] d; } ent_t;
   ent_t cur, nxt;
   bit acc, m_wr, last;
   logic [31:0] m_addr, m_wdata;
   logic [1:0] m_size, e_rdy;
   always @(negedge clk) begin
      automatic int win = (rv == 2'b11) ? (last ? 0 : 1) : (rv[1] ? 1 : 0);
      e_rdy = (rv != 2'b00 && !acc) ? 2'b01 << win : 2'b00;
      if (chk_en) begin
         chk("req_ready", req_ready, e_rdy);
         chk("rsp_valid", rsp_valid, cur.v ? 2'b01 << cur.p : 2'b00);
         for (int p = 0; p < 2; p++) begin
            chk("rsp_rdata", rsp_rdata[p], (cur.v && cur.p == p) ? cur.d : 32'd0);
            chk("rsp_err", rsp_err[p], cur.v && cur.p == p && cur.e);
         end
         chk("mem_write", mem_write, acc && m_wr);
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_size", mem_size, m_size);
         chk("mem_wdata", mem_wdata, m_wdata);
         if (mem_write) mw_cnt++;
      end
      if (!rst_n) begin
         cur = '{0, 0, 0, 0}; nxt = '{0, 0, 0, 0};
         acc = 0; m_wr = 0; last = 1; m_addr = 0; m_size = 0; m_wdata = 0;
      end else begin
         cur = nxt; nxt = '{0, 0, 0, 0}; acc = 0;
         if (e_rdy != 2'b00) begin
            automatic longint a = ra[win];
            automatic int s = rs[win];
            automatic int nb = (s == 3) ? 4 : (1 << s);
            automatic bit bad = s == 3 || a % nb != 0 || a + nb > 4096;
            last = win[0];
            if (bad) cur = '{1, win[0], 1, 0};
            else begin
               acc = 1; m_wr = rw[win]; m_addr = ra[win]; m_size = rs[win]; m_wdata = rwd[win];
               if (rw[win]) for (int i = 0; i < nb; i++) rm[int'(a) + i] = rwd[win][8*i +: 8];
               nxt = '{1, win[0], 0, rw[win] ? 32'd0 : ld(int'(a), s)};
            end
         end
      end
   end
   task automatic do_req(input int p, input bit w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rdat, output logic er, output int lat);
      int n = 0;
      rdat = 'x; er = 'x; lat = -1;
      rw[p] = w; rs[p] = sz; ra[p] = a; rwd[p] = d; rv[p] = 1'b1;
      forever begin
         @(negedge clk);
         if (req_ready[p]) break;
         if (++n > 20) begin
            checks++; failures++;
            $display("FAIL handshake_timeout port=%0d got=none exp=ready", p);
            @(posedge clk); #1 rv[p] = 1'b0;
            return;
         end
      end
      @(posedge clk); #1 rv[p] = 1'b0;
      for (lat = 1; lat <= 10; lat++) begin
         @(negedge clk);
         if (rsp_valid[p]) begin rdat = rsp_rdata[p]; er = rsp_err[p]; break; end
      end
      @(posedge clk); #1;
   endtask
   initial begin
      logic [31:0] rd;
      logic er;
      int lat, ng, g[10], cy[10], f0, f1, mw0, bad_cnt;
      for (int i = 0; i < 4096; i++) begin dm[i] = 8'h00; rm[i] = 8'h00; end
      @(posedge clk); #1 chk_en = 1'b1;
      @(negedge clk);
      chk("reset_ready", req_ready, 2'b00);
      chk("reset_rsp", {rsp_valid, rsp_err, mem_write}, 5'd0);
      chk("reset_mem", {mem_addr, mem_wdata, mem_size}, 66'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      do_req(0, 1, 2'd2, 32'd16, 32'hDEADBEEF, rd, er, lat);
      chk("p0_sw_err", er, 0); chk("p0_sw_lat", lat, 2);
      do_req(0, 0, 2'd2, 32'd16, 32'h0, rd, er, lat);
      chk("p0_lw_data", rd, 32'hDEADBEEF); chk("p0_lw_err", er, 0); chk("p0_lw_lat", lat, 2);
      do_req(1, 1, 2'd0, 32'd8, 32'h123456AA, rd, er, lat);
      chk("p1_sb_lat", lat, 2);
      do_req(1, 0, 2'd0, 32'd8, 32'h0, rd, er, lat);
      chk("p1_lb_data", rd, 32'h000000AA); chk("p1_lb_lat", lat, 2);
      mw0 = mw_cnt; bad_cnt = 0;
      do_req(0, 1, 2'd1, 32'd13, 32'hFFFF, rd, er, lat);
      bad_cnt += (er === 1'b1 && lat == 1 && rd === 32'd0) ? 1 : 0;
      do_req(0, 0, 2'd2, 32'h1002, 32'h0, rd, er, lat);
      bad_cnt += (er === 1'b1 && lat == 1 && rd === 32'd0) ? 1 : 0;
      do_req(0, 1, 2'd0, 32'd4096, 32'h55, rd, er, lat);
      bad_cnt += (er === 1'b1 && lat == 1 && rd === 32'd0) ? 1 : 0;
      do_req(1, 1, 2'd3, 32'd0, 32'h77, rd, er, lat);
      bad_cnt += (er === 1'b1 && lat == 1 && rd === 32'd0) ? 1 : 0;
      chk("err_responses", bad_cnt, 4);
      chk("err_no_mem_write", mw_cnt - mw0, 0);
      chk("err_mem_intact", {dm[15], dm[14], dm[13], dm[12], dm[0]}, 40'd0);
      chk("word16_intact", {dm[19], dm[18], dm[17], dm[16]}, 32'hDEADBEEF);
      do_req(0, 0, 2'd2, 32'd4092, 32'h0, rd, er, lat);
      chk("top_word_ok", {er, lat[3:0]}, 5'd2);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      rw = 2'b00; rs[0] = 2'd2; ra[0] = 32'd16; rs[1] = 2'd0; ra[1] = 32'd8; rv = 2'b11;
      ng = 0; f0 = 0; f1 = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (req_ready != 2'b00 && ng < 10) begin g[ng] = req_ready[1]; cy[ng] = i; ng++; end
         f0 += r2_ready[0]; f1 += r2_ready[1];
      end
      @(posedge clk); #1 rv = 2'b00;
      chk("rr_grants", ng, 5);
      for (int i = 0; i < ng && i < 5; i++) begin
         chk("rr_port", g[i], i % 2);
         chk("rr_cycle", cy[i], 2 * i);
      end
      chk("fp_p0_grants", f0, 5);
      chk("fp_p1_grants", f1, 0);
      repeat (3) @(posedge clk); #1;
      rw[0] = 1'b1; rs[0] = 2'd2; ra[0] = 32'd20; rwd[0] = 32'h12345678; rv[0] = 1'b1;
      for (int n = 0; n <= 20; n++) begin
         @(negedge clk);
         if (req_ready[0]) break;
         if (n == 20) begin checks++; failures++; $display("FAIL rst_hs_timeout got=none exp=ready"); end
      end
      @(posedge clk); #1 rv[0] = 1'b0; rst_n = 1'b0;
      @(negedge clk); chk("rst_access_write", mem_write, 1);
      @(posedge clk); #1 rst_n = 1'b1;
      f0 = 0;
      repeat (4) begin @(negedge clk); f0 += (rsp_valid != 2'b00) ? 1 : 0; end
      chk("rst_drop_rsp", f0, 0);
      @(posedge clk); #1;
      do_req(0, 0, 2'd2, 32'd20, 32'h0, rd, er, lat);
      chk("rst_store_kept", rd, 32'h12345678);
      bad_cnt = 0;
      for (int i = 0; i < 4096; i++) bad_cnt += (dm[i] !== rm[i]) ? 1 : 0;
      chk("mem_vs_model", bad_cnt, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
